// File: rtl/raw_capture_pkg.sv
// raw_capture_pkg: FSM state encodings and MCB bus constants shared by the raw capture engine.
package raw_capture_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WRITE  = 3'd1,
        S_DONE   = 3'd3,
        S_READ   = 3'd4,
        S_WAIT_R = 3'd5
    } state_t;

    localparam int MCB_DW = 32;

endpackage

// File: rtl/raw_fifo.sv
// raw_fifo: single-clock FIFO with extra-MSB pointers; clear_i empties it but still accepts a same-cycle push.
module raw_fifo #(
    parameter int W     = 24,
    parameter int BBITS = 9
) (
    input  logic           clock_i,
    input  logic           reset_i,
    input  logic           clear_i,
    input  logic           push_i,
    input  logic           pop_i,
    input  logic [W-1:0]   data_i,
    output logic [W-1:0]   data_o,
    output logic           full_o,
    output logic           empty_o,
    output logic [BBITS:0] level_o
);

    logic [W-1:0]     r_mem [2**BBITS];
    logic [BBITS:0]   r_wp, r_rp;
    logic             w_we, w_re;
    logic [BBITS-1:0] w_wa;

    assign empty_o = r_wp == r_rp;
    assign full_o  = r_wp[BBITS] != r_rp[BBITS] && r_wp[BBITS-1:0] == r_rp[BBITS-1:0];
    assign level_o = r_wp - r_rp;
    assign data_o  = r_mem[r_rp[BBITS-1:0]];
    // A push into a full FIFO only lands if the head leaves in the same cycle.
    assign w_we    = push_i && (clear_i || !full_o || pop_i);
    assign w_re    = pop_i && !empty_o;
    assign w_wa    = clear_i ? '0 : r_wp[BBITS-1:0];

    always_ff @(posedge clock_i) begin
        if (w_we)
            r_mem[w_wa] <= data_i;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_wp <= '0;
            r_rp <= '0;
        end else if (clear_i) begin
            r_wp <= {{BBITS{1'b0}}, push_i};
            r_rp <= '0;
        end else begin
            r_wp <= r_wp + {{BBITS{1'b0}}, w_we};
            r_rp <= r_rp + {{BBITS{1'b0}}, w_re};
        end
    end

endmodule

// File: rtl/raw_capture.sv
// raw_capture: buffers strobed antenna samples in a FIFO and drains them as single-word MCB writes.
// Define TART_RAW_READBACK_EN to add the request-driven SDRAM readback path (READ/WAIT_R states).
module raw_capture
    import raw_capture_pkg::*;
#(
    parameter int AXNUM = 24,
    parameter int MSB   = AXNUM - 1,
    parameter int ABITS = 21,
    parameter int ASB   = ABITS - 1,
    parameter int BBITS = 9,
    parameter int DELAY = 3
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              capture_i,
    input  logic              wrap_i,
    input  logic              strobe_i,
    input  logic [MSB:0]      signal_i,
    input  logic              request_i,
    output logic [MSB:0]      rd_dat_o,
    output logic              rd_vld_o,
    output logic              mcb_ce_o,
    output logic              mcb_wr_o,
    input  logic              mcb_rdy_i,
    output logic [ASB:0]      mcb_adr_o,
    output logic [MCB_DW-1:0] mcb_dat_o,
    input  logic [MCB_DW-1:0] mcb_dat_i,
    input  logic              mcb_ack_i,
    output logic              full_o,
    output logic              oflow_o,
    output logic [BBITS:0]    level_o,
    output logic [2:0]        state_o
);

    state_t            r_state;
    logic              r_cap, r_ce, r_full, r_oflow;
    logic [ASB:0]      r_adr, r_wr_adr;
    logic [MCB_DW-1:0] r_dat;
    logic              w_rise, w_push, w_pop, w_clear, w_ffull, w_fempty, w_unused;
    logic [MSB:0]      w_head;
    logic [BBITS:0]    w_level;

    assign w_rise  = capture_i && !r_cap;
    // Stopped (one-shot region full) is lifted by the capture start that clears full_o.
    assign w_push  = strobe_i && capture_i && !(r_full && !wrap_i && !w_rise) && r_state != S_DONE;
    assign w_pop   = r_state == S_WRITE && mcb_rdy_i;
    assign w_clear = w_rise || r_state == S_DONE;

    raw_fifo #(
        .W     (AXNUM),
        .BBITS (BBITS)
    ) u_fifo (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .clear_i (w_clear),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .data_i  (signal_i),
        .data_o  (w_head),
        .full_o  (w_ffull),
        .empty_o (w_fempty),
        .level_o (w_level)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_cap   <= 1'b0;
            r_oflow <= 1'b0;
        end else begin
            r_cap   <= capture_i;
            r_oflow <= !w_rise && (r_oflow || (w_push && w_ffull && !w_pop));
        end
    end

`ifdef TART_RAW_READBACK_EN
    logic         r_wr, r_req, r_rd_vld;
    logic [ASB:0] r_rd_adr;
    logic [MSB:0] r_rd_dat;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state  <= S_IDLE;
            r_ce     <= 1'b0;
            r_wr     <= 1'b0;
            r_adr    <= '0;
            r_dat    <= '0;
            r_wr_adr <= '0;
            r_full   <= 1'b0;
            r_req    <= 1'b0;
            r_rd_vld <= 1'b0;
            r_rd_adr <= '0;
            r_rd_dat <= '0;
        end else begin
            r_rd_vld <= 1'b0;
            r_req    <= r_req || request_i;
            case (r_state)
                S_IDLE:
                    if (!w_fempty && !w_rise) begin
                        r_state <= S_WRITE;
                        r_ce    <= 1'b1;
                        r_wr    <= 1'b1;
                        r_adr   <= r_wr_adr;
                        r_dat   <= MCB_DW'(w_head);
                    end else if (w_fempty && r_req && !capture_i) begin
                        r_state <= S_READ;
                        r_ce    <= 1'b1;
                        r_wr    <= 1'b0;
                        r_adr   <= r_rd_adr;
                        r_req   <= 1'b0;
                    end
                S_WRITE:
                    if (mcb_rdy_i) begin
                        r_ce     <= 1'b0;
                        r_wr_adr <= r_wr_adr + 1'b1;
                        r_full   <= r_full || &r_wr_adr;
                        r_state  <= &r_wr_adr && !wrap_i && !w_rise ? S_DONE : S_IDLE;
                    end
                S_DONE:
                    if (!capture_i)
                        r_state <= S_IDLE;
                S_READ:
                    if (mcb_rdy_i) begin
                        r_ce    <= 1'b0;
                        r_state <= S_WAIT_R;
                    end
                S_WAIT_R:
                    if (mcb_ack_i) begin
                        r_rd_dat <= mcb_dat_i[MSB:0];
                        r_rd_vld <= 1'b1;
                        r_rd_adr <= r_rd_adr + 1'b1;
                        r_state  <= S_IDLE;
                    end
                default:
                    r_state <= S_IDLE;
            endcase
            if (w_rise) begin
                r_wr_adr <= '0;
                r_rd_adr <= '0;
                r_full   <= 1'b0;
            end
        end
    end

    assign mcb_wr_o = r_wr;
    assign rd_dat_o = r_rd_dat;
    assign rd_vld_o = r_rd_vld;
    assign w_unused = ^{mcb_dat_i, DELAY};
`else
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state  <= S_IDLE;
            r_ce     <= 1'b0;
            r_adr    <= '0;
            r_dat    <= '0;
            r_wr_adr <= '0;
            r_full   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE:
                    if (!w_fempty && !w_rise) begin
                        r_state <= S_WRITE;
                        r_ce    <= 1'b1;
                        r_adr   <= r_wr_adr;
                        r_dat   <= MCB_DW'(w_head);
                    end
                S_WRITE:
                    if (mcb_rdy_i) begin
                        r_ce     <= 1'b0;
                        r_wr_adr <= r_wr_adr + 1'b1;
                        r_full   <= r_full || &r_wr_adr;
                        r_state  <= &r_wr_adr && !wrap_i && !w_rise ? S_DONE : S_IDLE;
                    end
                S_DONE:
                    if (!capture_i)
                        r_state <= S_IDLE;
                default:
                    r_state <= S_IDLE;
            endcase
            if (w_rise) begin
                r_wr_adr <= '0;
                r_full   <= 1'b0;
            end
        end
    end

    assign mcb_wr_o = r_ce;
    assign rd_dat_o = '0;
    assign rd_vld_o = 1'b0;
    assign w_unused = ^{request_i, mcb_ack_i, mcb_dat_i, DELAY};
`endif

    assign mcb_ce_o  = r_ce;
    assign mcb_adr_o = r_adr;
    assign mcb_dat_o = r_dat;
    assign full_o    = r_full;
    assign oflow_o   = r_oflow;
    assign level_o   = w_level;
    assign state_o   = r_state;

endmodule

// File: tb/tb_raw_capture.sv
// tb_raw_capture: vector table, directed corner sequences and a queue-based scoreboard for raw_capture.
module tb_raw_capture;

    localparam int AXNUM = 24;
    localparam int ABITS = 4;
    localparam int BBITS = 2;
    localparam int DEPTH = 1 << BBITS;
    localparam int NADR  = 1 << ABITS;

    logic              clock_i = 1'b0;
    logic              reset_i, capture_i, wrap_i, strobe_i, request_i, mcb_rdy_i, mcb_ack_i;
    logic [AXNUM-1:0]  signal_i, rd_dat_o;
    logic              rd_vld_o, mcb_ce_o, mcb_wr_o, full_o, oflow_o;
    logic [ABITS-1:0]  mcb_adr_o;
    logic [31:0]       mcb_dat_o, mcb_dat_i;
    logic [BBITS:0]    level_o;
    logic [2:0]        state_o;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [ABITS-1:0] adr; logic [31:0] dat; } wr_t;
    wr_t wlog[$];

    typedef struct packed {
        logic             stb;
        logic [AXNUM-1:0] sig;
        logic             rdy;
        logic             ce;
        logic [ABITS-1:0] adr;
        logic [31:0]      dat;
        logic [BBITS:0]   lvl;
        logic [2:0]       st;
    } vec_t;
    vec_t tbl [11];

    raw_capture #(
        .AXNUM (AXNUM),
        .ABITS (ABITS),
        .BBITS (BBITS)
    ) dut (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .capture_i (capture_i),
        .wrap_i    (wrap_i),
        .strobe_i  (strobe_i),
        .signal_i  (signal_i),
        .request_i (request_i),
        .rd_dat_o  (rd_dat_o),
        .rd_vld_o  (rd_vld_o),
        .mcb_ce_o  (mcb_ce_o),
        .mcb_wr_o  (mcb_wr_o),
        .mcb_rdy_i (mcb_rdy_i),
        .mcb_adr_o (mcb_adr_o),
        .mcb_dat_o (mcb_dat_o),
        .mcb_dat_i (mcb_dat_i),
        .mcb_ack_i (mcb_ack_i),
        .full_o    (full_o),
        .oflow_o   (oflow_o),
        .level_o   (level_o),
        .state_o   (state_o)
    );

    always #5 clock_i = ~clock_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Logs any write the MCB accepts at the coming edge, then steps to 1ns past it.
    task automatic tick();
        wr_t w;
        if (mcb_ce_o && mcb_wr_o && mcb_rdy_i) begin
            w.adr = mcb_adr_o;
            w.dat = mcb_dat_o;
            wlog.push_back(w);
        end
        @(posedge clock_i);
        #1;
    endtask

    task automatic new_capture(input logic wrap);
        strobe_i  = 1'b0;
        capture_i = 1'b0;
        tick();
        capture_i = 1'b1;
        wrap_i    = wrap;
        tick();
        wlog.delete();
    endtask

    task automatic strobe_burst(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            strobe_i = 1'b1;
            signal_i = AXNUM'(base + i);
            tick();
            strobe_i = 1'b0;
            tick();
        end
        for (int i = 0; i < 10; i++) tick();
    endtask

    initial begin
        logic [AXNUM-1:0] q[$];
        int               madr;
        logic             mfull, moflow, acc, drop;
        int               n;

        reset_i = 1'b0; capture_i = 1'b0; wrap_i = 1'b0; strobe_i = 1'b0; signal_i = '0;
        request_i = 1'b0; mcb_rdy_i = 1'b1; mcb_ack_i = 1'b0; mcb_dat_i = '0;
        #2 reset_i = 1'b1;
        @(posedge clock_i);
        @(posedge clock_i);
        #1;
        chk("reset_ce", mcb_ce_o, 0);
        chk("reset_wr", mcb_wr_o, 0);
        chk("reset_adr", mcb_adr_o, 0);
        chk("reset_dat", mcb_dat_o, 0);
        chk("reset_flags", {full_o, oflow_o, rd_vld_o}, 0);
        chk("reset_level", level_o, 0);
        chk("reset_state", state_o, 0);
        reset_i = 1'b0;
        tick();

        // stb sig rdy | ce adr dat lvl st  (one row per clock)
        tbl[0]  = '{1'b1, 24'd1, 1'b1, 1'b0, 4'd0, 32'd0, 3'd1, 3'd0};
        tbl[1]  = '{1'b0, 24'd0, 1'b1, 1'b1, 4'd0, 32'd1, 3'd1, 3'd1};
        tbl[2]  = '{1'b1, 24'd2, 1'b1, 1'b0, 4'd0, 32'd0, 3'd1, 3'd0};
        tbl[3]  = '{1'b0, 24'd0, 1'b1, 1'b1, 4'd1, 32'd2, 3'd1, 3'd1};
        tbl[4]  = '{1'b0, 24'd0, 1'b0, 1'b1, 4'd1, 32'd2, 3'd1, 3'd1};
        tbl[5]  = '{1'b0, 24'd0, 1'b1, 1'b0, 4'd0, 32'd0, 3'd0, 3'd0};
        tbl[6]  = '{1'b1, 24'd3, 1'b0, 1'b0, 4'd0, 32'd0, 3'd1, 3'd0};
        tbl[7]  = '{1'b1, 24'd4, 1'b0, 1'b1, 4'd2, 32'd3, 3'd2, 3'd1};
        tbl[8]  = '{1'b0, 24'd0, 1'b1, 1'b0, 4'd0, 32'd0, 3'd1, 3'd0};
        tbl[9]  = '{1'b0, 24'd0, 1'b1, 1'b1, 4'd3, 32'd4, 3'd1, 3'd1};
        tbl[10] = '{1'b0, 24'd0, 1'b1, 1'b0, 4'd0, 32'd0, 3'd0, 3'd0};

        new_capture(1'b0);
        for (int i = 0; i < 11; i++) begin
            strobe_i  = tbl[i].stb;
            signal_i  = tbl[i].sig;
            mcb_rdy_i = tbl[i].rdy;
            tick();
            chk($sformatf("vec%0d_ce", i), mcb_ce_o, tbl[i].ce);
            chk($sformatf("vec%0d_level", i), level_o, tbl[i].lvl);
            chk($sformatf("vec%0d_state", i), state_o, tbl[i].st);
            if (tbl[i].ce) begin
                chk($sformatf("vec%0d_adr", i), mcb_adr_o, tbl[i].adr);
                chk($sformatf("vec%0d_dat", i), mcb_dat_o, tbl[i].dat);
            end
        end

        // One-shot: only the first 2^ABITS samples reach SDRAM, then DONE.
        new_capture(1'b0);
        mcb_rdy_i = 1'b1;
        strobe_burst(20, 100);
        chk("oneshot_count", wlog.size(), NADR);
        for (int i = 0; i < wlog.size() && i < NADR; i++) begin
            chk($sformatf("oneshot_adr%0d", i), wlog[i].adr, i);
            chk($sformatf("oneshot_dat%0d", i), wlog[i].dat, 100 + i);
        end
        chk("oneshot_full", full_o, 1);
        chk("oneshot_state", state_o, 3);
        chk("oneshot_level", level_o, 0);
        chk("oneshot_ce", mcb_ce_o, 0);
        capture_i = 1'b0;
        tick();
        chk("done_exit", state_o, 0);

        // Circular: addresses wrap back to 0.
        new_capture(1'b1);
        strobe_burst(20, 200);
        chk("circ_count", wlog.size(), 20);
        for (int i = 0; i < wlog.size() && i < 20; i++) begin
            chk($sformatf("circ_adr%0d", i), wlog[i].adr, i % NADR);
            chk($sformatf("circ_dat%0d", i), wlog[i].dat, 200 + i);
        end
        chk("circ_full", full_o, 1);
        chk("circ_state", state_o, 0);

        // Overflow with a stalled MCB.
        new_capture(1'b1);
        mcb_rdy_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            strobe_i = 1'b1;
            signal_i = AXNUM'(300 + i);
            tick();
        end
        strobe_i = 1'b0;
        tick();
        chk("ovf_level", level_o, DEPTH);
        chk("ovf_flag", oflow_o, 1);
        chk("ovf_ce_held", mcb_ce_o, 1);
        mcb_rdy_i = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk("ovf_count", wlog.size(), DEPTH);
        for (int i = 0; i < wlog.size() && i < DEPTH; i++)
            chk($sformatf("ovf_dat%0d", i), wlog[i].dat, 300 + i);
        chk("ovf_drained", level_o, 0);
        chk("ovf_sticky", oflow_o, 1);
        capture_i = 1'b0;
        tick();
        capture_i = 1'b1;
        tick();
        chk("ovf_cleared", oflow_o, 0);

        // Random circular capture against a FIFO-level scoreboard.
        new_capture(1'b1);
        q.delete();
        madr = 0; mfull = 1'b0; moflow = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            strobe_i  = $urandom_range(99) < 45;
            signal_i  = AXNUM'($urandom);
            mcb_rdy_i = $urandom_range(99) < 60;
            acc  = mcb_ce_o && mcb_wr_o && mcb_rdy_i;
            drop = strobe_i && q.size() == DEPTH && !acc;
            if (acc) begin
                if (q.size() == 0) begin
                    chk("rnd_spurious_write", 1, 0);
                end else begin
                    chk("rnd_adr", mcb_adr_o, madr);
                    chk("rnd_dat", mcb_dat_o, {8'h00, q[0]});
                    void'(q.pop_front());
                end
                mfull = mfull || madr == NADR - 1;
                madr  = (madr + 1) % NADR;
            end
            if (drop) moflow = 1'b1;
            else if (strobe_i) q.push_back(signal_i);
            tick();
            chk("rnd_level", level_o, q.size());
            chk("rnd_oflow", oflow_o, moflow);
            chk("rnd_full", full_o, mfull);
`ifndef TART_RAW_READBACK_EN
            chk("rnd_wr_eq_ce", mcb_wr_o, mcb_ce_o);
`endif
        end
        wlog.delete();

        // Drain and stop capture.
        strobe_i = 1'b0; capture_i = 1'b0; mcb_rdy_i = 1'b1;
        n = 0;
        while (n < 30 && (level_o != 0 || state_o != 0 || mcb_ce_o)) begin
            tick();
            n++;
        end
        chk("drain_done", n < 30, 1);

`ifdef TART_RAW_READBACK_EN
        for (int r = 0; r < 2; r++) begin
            request_i = 1'b1;
            tick();
            request_i = 1'b0;
            n = 0;
            while (n < 10 && !(mcb_ce_o && !mcb_wr_o)) begin
                tick();
                n++;
            end
            chk($sformatf("rb%0d_req_seen", r), n < 10, 1);
            chk($sformatf("rb%0d_adr", r), mcb_adr_o, r);
            tick();
            chk($sformatf("rb%0d_wait", r), state_o, 5);
            mcb_ack_i = 1'b1;
            mcb_dat_i = 32'hAB123456 + r;
            tick();
            mcb_ack_i = 1'b0;
            chk($sformatf("rb%0d_vld", r), rd_vld_o, 1);
            chk($sformatf("rb%0d_dat", r), rd_dat_o, 24'h123456 + r);
            chk($sformatf("rb%0d_idle", r), state_o, 0);
            tick();
            chk($sformatf("rb%0d_vld_pulse", r), rd_vld_o, 0);
        end
`else
        request_i = 1'b1; mcb_ack_i = 1'b1; mcb_dat_i = 32'hAB123456;
        tick();
        request_i = 1'b0;
        tick();
        tick();
        mcb_ack_i = 1'b0;
        chk("norb_vld", rd_vld_o, 0);
        chk("norb_dat", rd_dat_o, 0);
        chk("norb_ce", mcb_ce_o, 0);
        chk("norb_state", state_o, 0);
`endif

        // Async reset while a write is stalled.
        new_capture(1'b1);
        mcb_rdy_i = 1'b0;
        strobe_i = 1'b1;
        signal_i = 24'h5A5A5A;
        tick();
        strobe_i = 1'b0;
        n = 0;
        while (n < 5 && !mcb_ce_o) begin
            tick();
            n++;
        end
        chk("arst_in_write", state_o, 1);
        #2 reset_i = 1'b1;
        #1;
        chk("arst_ce", mcb_ce_o, 0);
        chk("arst_wr", mcb_wr_o, 0);
        chk("arst_adr", mcb_adr_o, 0);
        chk("arst_dat", mcb_dat_o, 0);
        chk("arst_flags", {full_o, oflow_o, rd_vld_o}, 0);
        chk("arst_level", level_o, 0);
        chk("arst_state", state_o, 0);
        reset_i = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
